// File: rtl/clp_isa_pkg.sv
// CLP instruction-set constants, opcode classification and the scheduler state encoding,
// shared by the scheduler top and its fetch unit.
package clp_isa_pkg;

  localparam int OPC_MSB     = 63;
  localparam int OPC_LSB     = 60;
  localparam int BARRIER_BIT = 59;
  localparam int PAYLOAD_W   = 60;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOADF = 4'h1;
  localparam logic [3:0] OP_LOADW = 4'h2;
  localparam logic [3:0] OP_CONV  = 4'h3;
  localparam logic [3:0] OP_SAVE  = 4'h4;
  localparam logic [3:0] OP_END   = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_BARRIER,
    S_DONE,
    S_ERR
  } state_e;

  // Which execution unit (or control action) an opcode maps to.
  typedef enum logic [2:0] {
    K_NOP,
    K_LOAD,
    K_COMP,
    K_SAVE,
    K_END,
    K_ILL
  } kind_e;

  function automatic kind_e op_kind(input logic [3:0] opc);
    case (opc)
      OP_NOP:             return K_NOP;
      OP_LOADF, OP_LOADW: return K_LOAD;
      OP_CONV:            return K_COMP;
      OP_SAVE:            return K_SAVE;
      OP_END:             return K_END;
      default:            return K_ILL;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Program counter, read strobe, read-latency counter and instruction register.
// instr_valid_o marks the cycle in which memory data is captured; cap_instr_o is that data.
module instr_fetch_unit
  import clp_isa_pkg::*;
#(
  parameter int INSTR_W = 64,
  parameter int ADDR_W  = 8,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               fetch_i,
  input  logic               advance_i,
  input  logic [INSTR_W-1:0] rd_data_i,
  output logic               rd_en_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] cap_instr_o,
  output logic [INSTR_W-1:0] instr_o
);

  localparam logic [1:0] CNT_LAST = 2'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  logic [ADDR_W-1:0]  pc_q;
  logic [1:0]         cnt_q;
  logic               wait_q;
  logic [INSTR_W-1:0] instr_q;
  logic               capture;

  generate
    if (RD_LAT == 0) begin : g_comb_mem
      assign capture = fetch_i;
    end else begin : g_reg_mem
      assign capture = wait_q && (cnt_q == CNT_LAST);
    end
  endgenerate

  assign rd_en_o       = fetch_i;
  assign addr_o        = pc_q;
  assign instr_valid_o = capture;
  assign cap_instr_o   = rd_data_i;
  assign instr_o       = instr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      cnt_q   <= '0;
      wait_q  <= 1'b0;
      instr_q <= '0;
    end else begin
      if (start_i) begin
        pc_q <= '0;
      end else if (advance_i) begin
        pc_q <= pc_q + 1'b1;
      end

      if (fetch_i && (RD_LAT != 0)) begin
        wait_q <= 1'b1;
        cnt_q  <= '0;
      end else if (wait_q) begin
        if (cnt_q == CNT_LAST) begin
          wait_q <= 1'b0;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      if (capture) begin
        instr_q <= rd_data_i;
      end
    end
  end

endmodule

// File: rtl/instr_sched_ctrl.sv
// CLP instruction sequencer: fetches from address 0 on start, decodes each opcode and
// hands the payload to the load/compute/save unit over valid/ready until END.
module instr_sched_ctrl
  import clp_isa_pkg::*;
#(
  parameter int INSTR_W = 64,
  parameter int ADDR_W  = 8,
  parameter int RD_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc_enable,
  input  logic [INSTR_W-1:0]   instr_port,
  output logic [ADDR_W-1:0]    instr_fetch_addr,
  output logic                 instr_rd_en,
  output logic [PAYLOAD_W-1:0] cmd_payload,
  output logic                 load_valid,
  input  logic                 load_ready,
  output logic                 comp_valid,
  input  logic                 comp_ready,
  output logic                 save_valid,
  input  logic                 save_ready,
  input  logic                 load_busy,
  input  logic                 comp_busy,
  input  logic                 save_busy,
  output logic                 clp_busy,
  output logic                 prog_done,
  output logic                 prog_err
);

  state_e state_q;
  logic   load_valid_q, comp_valid_q, save_valid_q;
  logic   clp_busy_q, prog_done_q, prog_err_q;

  logic               cap_valid;
  logic [INSTR_W-1:0] cap_instr;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc;
  logic               start, fetch_go, advance;
  logic               units_idle, xfer, pc_last, dec_now;
  logic [INSTR_W-1:0] dec_instr;
  kind_e              dec_kind;

  assign start      = (state_q == S_IDLE) && acc_enable;
  assign fetch_go   = (state_q == S_FETCH);
  assign units_idle = !(load_busy || comp_busy || save_busy);
  assign xfer       = (load_valid_q && load_ready) || (comp_valid_q && comp_ready)
                   || (save_valid_q && save_ready);
  assign pc_last    = &pc;

  // Decode straight from the memory data on capture so a fetch costs no extra cycle;
  // a barrier instruction is decoded later from the instruction register.
  assign dec_instr = (state_q == S_BARRIER) ? instr_q : cap_instr;
  assign dec_kind  = op_kind(dec_instr[OPC_MSB:OPC_LSB]);
  assign dec_now   = (((state_q == S_FETCH) || (state_q == S_WAIT)) && cap_valid
                      && !cap_instr[BARRIER_BIT])
                   || ((state_q == S_BARRIER) && units_idle);

  // A retirement at the last address would wrap the PC, so it is trapped instead.
  assign advance = !pc_last && ((dec_now && (dec_kind == K_NOP))
                                || ((state_q == S_ISSUE) && xfer));

  instr_fetch_unit #(
    .INSTR_W (INSTR_W),
    .ADDR_W  (ADDR_W),
    .RD_LAT  (RD_LAT)
  ) u_fetch (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .fetch_i       (fetch_go),
    .advance_i     (advance),
    .rd_data_i     (instr_port),
    .rd_en_o       (instr_rd_en),
    .addr_o        (instr_fetch_addr),
    .instr_valid_o (cap_valid),
    .cap_instr_o   (cap_instr),
    .instr_o       (instr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      load_valid_q <= 1'b0;
      comp_valid_q <= 1'b0;
      save_valid_q <= 1'b0;
      clp_busy_q   <= 1'b0;
      prog_done_q  <= 1'b0;
      prog_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (acc_enable) begin
            state_q    <= S_FETCH;
            clp_busy_q <= 1'b1;
            prog_err_q <= 1'b0;
          end
        end
        S_FETCH, S_WAIT: begin
          if (!cap_valid) begin
            state_q <= S_WAIT;
          end else if (cap_instr[BARRIER_BIT]) begin
            state_q <= S_BARRIER;
          end
        end
        S_BARRIER: ;
        S_ISSUE: begin
          if (xfer) begin
            load_valid_q <= 1'b0;
            comp_valid_q <= 1'b0;
            save_valid_q <= 1'b0;
            if (pc_last) begin
              state_q    <= S_ERR;
              prog_err_q <= 1'b1;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          if (prog_done_q) begin
            prog_done_q <= 1'b0;
            clp_busy_q  <= 1'b0;
            state_q     <= S_IDLE;
          end else if (units_idle) begin
            prog_done_q <= 1'b1;
          end
        end
        S_ERR: begin
          clp_busy_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (dec_now) begin
        case (dec_kind)
          K_NOP: begin
            if (pc_last) begin
              state_q    <= S_ERR;
              prog_err_q <= 1'b1;
            end else begin
              state_q <= S_FETCH;
            end
          end
          K_LOAD: begin
            load_valid_q <= 1'b1;
            state_q      <= S_ISSUE;
          end
          K_COMP: begin
            comp_valid_q <= 1'b1;
            state_q      <= S_ISSUE;
          end
          K_SAVE: begin
            save_valid_q <= 1'b1;
            state_q      <= S_ISSUE;
          end
          K_END: state_q <= S_DONE;
          default: begin
            state_q    <= S_ERR;
            prog_err_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign cmd_payload = instr_q[PAYLOAD_W-1:0];
  assign load_valid  = load_valid_q;
  assign comp_valid  = comp_valid_q;
  assign save_valid  = save_valid_q;
  assign clp_busy    = clp_busy_q;
  assign prog_done   = prog_done_q;
  assign prog_err    = prog_err_q;

endmodule
